rasgs_randomizer_core: RTL
==========================

Name: rasgs_randomizer_core

Overview:
- Parametrised successor to the TinyTapeout randomizer top: a Galois-LFSR random source with configurable width and taps.
- Adds runtime reseeding, a valid/ready output handshake and bounded rejection sampling into [0, range_max].
- Sits under the tt_ top wrapper, which maps ui_in/uio_in/uo_out onto its ports.

Parameters:
- WIDTH, 16, LFSR state width (>= OUT_W).
- TAPS, 16'hB400, Galois feedback mask (WIDTH bits).
- SEED_DEFAULT, 16'hACE1, reset seed and substitute for a zero seed; must be nonzero.
- OUT_W, 8, output sample width.
- MAX_TRIES, 8, rejections allowed before the fallback reduction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enable generation.
- seed_valid  in  1  load seed_data this cycle.
- seed_data  in  WIDTH  new seed.
- range_max  in  OUT_W  inclusive upper bound; sampled at start of each value.
- rand_valid  out  1  sample available.
- rand_ready  in  1  consumer accepts.
- rand_data  out  OUT_W  sample.
- rand_fallback  out  1  sample produced by fallback path.

Behaviour:
- Reset values: lfsr=SEED_DEFAULT, state=IDLE, rand_valid=0, rand_data=0, rand_fallback=0, tries=0, range_q=0.
- LFSR step (one per STEP cycle): if lfsr[0], then lfsr <= (lfsr>>1)^TAPS, else lfsr <= lfsr>>1.
- Candidate = low OUT_W bits of the stepped value.
- States:
  - IDLE: hold, nothing steps. en=1 -> STEP; range_q <= range_max; tries <= 0.
  - STEP: step once.
    - Candidate <= range_q: register rand_data, rand_fallback=0 -> HOLD.
    - Else tries+1. If tries+1 == MAX_TRIES: fallback -> HOLD with rand_fallback=1. Else stay STEP.
    - en=0 in STEP: -> IDLE without stepping; tries cleared.
  - HOLD: rand_valid=1. rand_data/rand_fallback stable until handshake.
    - On rand_valid & rand_ready: -> STEP if en (range_q resampled, tries <= 0), else IDLE.
    - rand_valid deasserts the cycle after the handshake.
    - Max throughput is one sample per 2 cycles.
    - Once asserted, valid is never retracted by en=0.
- Fallback:
  - m = smallest all-ones mask >= range_q.
  - v = candidate & m; output v if v <= range_q, else v-(range_q+1).
  - The result is always in range.
- Latency: IDLE->STEP on en, first accepted sample visible as rand_valid 1 cycle after the STEP cycle.
- Seed load (highest priority, any state): lfsr <= (seed_data==0) ? SEED_DEFAULT : seed_data; tries <= 0.
  - Next state is STEP if en, else IDLE.
  - In HOLD with rand_ready=1 the same cycle, the transfer completes first.
  - In HOLD with rand_ready=0, the held sample is dropped (valid falls).
- Edge cases:
  - range_max all-ones: every candidate accepted.
  - range_max changes mid-value: ignored until the next value.
  - LFSR never reaches zero.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro RASGS_RAND_WHITEN_EN.
- Defined:
  - A WIDTH-bit Weyl counter w, reset 0, adds odd constant 'h9E37 (truncated to WIDTH) on each STEP cycle.
  - Candidate = low OUT_W bits of (stepped lfsr ^ w).
  - Seed load clears w.
- Undefined: no counter; candidate per above; test vectors below assume undefined.

Decomposition:
- Package rasgs_rand_pkg holds:
  - state enum {IDLE, STEP, HOLD};
  - default constants SEED_DEFAULT/TAPS;
  - function lfsr_next(state, taps);
  - function range_mask(range).
- Sub-module rasgs_range_sampler (combinational accept/fallback reduction) is natural; the LFSR and FSM stay in the core.

Test Plan:
- Reset, en=1, range_max=8'hFF, rand_ready=1 -> samples 8'h70, 8'h38, 8'h9C, all with fallback=0; valid high every other cycle.
- seed_valid with seed_data=0 then en=1, range 8'hFF -> identical sequence 8'h70, 8'h38 (zero seed substituted).
- range_max=8'h3F, ready=1 -> first sample 8'h38 (8'h70 rejected); second 8'h27 (8'h9C, 8'h4E rejected).
- range_max=8'h00, MAX_TRIES=8 -> rand_data=0 every sample; fallback=1 only when 8 consecutive nonzero candidates occur; valid never exceeds 1 per 2 cycles.
- Backpressure: ready=0 for 5 cycles in HOLD with en toggled 0 -> rand_valid/rand_data stable 8'h70; after ready pulse, state IDLE, valid 0.
- Reseed in HOLD with ready=0 -> valid falls next cycle, next sample equals first sample of the new seed; assert rst mid-STEP -> all outputs 0 immediately.

Source files
------------

// File: rtl/rasgs_rand_pkg.sv
// ============================================================================
// Module      : rasgs_rand_pkg
// Description : Shared FSM encoding, default constants and LFSR/range helpers
//               for the RASGS randomizer core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rasgs_rand_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [15:0] C_SEED_DEFAULT = 16'hACE1;
    localparam logic [15:0] C_TAPS         = 16'hB400;

    // Helpers work on a 64-bit container; callers zero-extend and truncate.
    function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                              input logic [63:0] taps);
        return state[0] ? ((state >> 1) ^ taps) : (state >> 1);
    endfunction

    // Smallest all-ones mask that covers rng.
    function automatic logic [63:0] range_mask(input logic [63:0] rng);
        logic [63:0] m;
        m = rng;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        m = m | (m >> 32);
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rasgs_range_sampler.sv
// ============================================================================
// Module      : rasgs_range_sampler
// Description : Combinational accept test and bounded fallback reduction of a
//               candidate into [0, range].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rasgs_range_sampler
    import rasgs_rand_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [OUT_W-1:0] i_candidate,
    input  logic [OUT_W-1:0] i_range,
    output logic             o_accept,
    output logic [OUT_W-1:0] o_fallback_data
);

    logic [OUT_W-1:0] w_mask;
    logic [OUT_W-1:0] w_masked;

    assign w_mask   = OUT_W'(range_mask(64'(i_range)));
    assign w_masked = i_candidate & w_mask;
    assign o_accept = (i_candidate <= i_range);

    // mask <= 2*range+1, so a single subtraction always lands in range
    assign o_fallback_data = (w_masked <= i_range) ? w_masked
                                                   : (w_masked - i_range - OUT_W'(1));

endmodule

`default_nettype wire

// File: rtl/rasgs_randomizer_core.sv
// ============================================================================
// Module      : rasgs_randomizer_core
// Description : Galois-LFSR random source with reseed, valid/ready output and
//               bounded rejection sampling. Optional whitening: RASGS_RAND_WHITEN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rasgs_randomizer_core
    import rasgs_rand_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(C_TAPS),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(C_SEED_DEFAULT),
    parameter int               OUT_W        = 8,
    parameter int               MAX_TRIES    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed_data,
    input  logic [OUT_W-1:0] range_max,
    output logic             rand_valid,
    input  logic             rand_ready,
    output logic [OUT_W-1:0] rand_data,
    output logic             rand_fallback
);

    localparam int C_TRY_W = $clog2(MAX_TRIES + 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_lfsr;
    logic [C_TRY_W-1:0] r_tries;
    logic [OUT_W-1:0]   r_range_q;
    logic               r_valid;
    logic [OUT_W-1:0]   r_data;
    logic               r_fallback;

    logic [WIDTH-1:0]   w_step;
    logic [OUT_W-1:0]   w_cand;
    logic [C_TRY_W-1:0] w_tries_inc;
    logic               w_accept;
    logic [OUT_W-1:0]   w_fb_data;

    assign w_step      = WIDTH'(lfsr_next(64'(r_lfsr), 64'(TAPS)));
    assign w_tries_inc = r_tries + C_TRY_W'(1);

`ifdef RASGS_RAND_WHITEN_EN
    localparam logic [WIDTH-1:0] C_WEYL_INC = WIDTH'(32'h9E37);
    logic [WIDTH-1:0] r_weyl;
    logic [WIDTH-1:0] w_white;
    assign w_white = w_step ^ r_weyl;
    assign w_cand  = w_white[OUT_W-1:0];
`else
    assign w_cand  = w_step[OUT_W-1:0];
`endif

    rasgs_range_sampler #(
        .OUT_W (OUT_W)
    ) u_sampler (
        .i_candidate     (w_cand),
        .i_range         (r_range_q),
        .o_accept        (w_accept),
        .o_fallback_data (w_fb_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lfsr     <= SEED_DEFAULT;
            r_tries    <= '0;
            r_range_q  <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_fallback <= 1'b0;
`ifdef RASGS_RAND_WHITEN_EN
            r_weyl     <= '0;
`endif
        end else if (seed_valid) begin
            // A pending sample either completes this cycle or is dropped
            r_lfsr  <= (seed_data == '0) ? SEED_DEFAULT : seed_data;
            r_tries <= '0;
            r_valid <= 1'b0;
`ifdef RASGS_RAND_WHITEN_EN
            r_weyl  <= '0;
`endif
            if (en) begin
                r_state   <= STEP;
                r_range_q <= range_max;
            end else begin
                r_state   <= IDLE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state   <= STEP;
                        r_range_q <= range_max;
                        r_tries   <= '0;
                    end
                end
                STEP: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_tries <= '0;
                    end else begin
                        r_lfsr <= w_step;
`ifdef RASGS_RAND_WHITEN_EN
                        r_weyl <= r_weyl + C_WEYL_INC;
`endif
                        if (w_accept) begin
                            r_data     <= w_cand;
                            r_fallback <= 1'b0;
                            r_valid    <= 1'b1;
                            r_state    <= HOLD;
                        end else if (w_tries_inc == C_TRY_W'(MAX_TRIES)) begin
                            r_data     <= w_fb_data;
                            r_fallback <= 1'b1;
                            r_valid    <= 1'b1;
                            r_state    <= HOLD;
                        end else begin
                            r_tries    <= w_tries_inc;
                        end
                    end
                end
                HOLD: begin
                    if (rand_ready) begin
                        r_valid <= 1'b0;
                        if (en) begin
                            r_state   <= STEP;
                            r_range_q <= range_max;
                            r_tries   <= '0;
                        end else begin
                            r_state   <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rand_valid    = r_valid;
    assign rand_data     = r_data;
    assign rand_fallback = r_fallback;

endmodule

`default_nettype wire
